// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS  = 8;

  // Bit period in clocks, rounded to the nearest integer.
  function automatic int calc_bit_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with show-ahead head output; DEPTH must be a power of 2.
module sync_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 frames.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [7:0]                  data,
  output logic                        tx,
  output logic                        busy,
  output logic                        done,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int                BIT_DIV  = calc_bit_div(CLK_FREQ, BAUD);
  localparam int                CNT_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(BIT_DIV - 1);
  localparam logic [2:0]        LAST_IDX = 3'(DATA_BITS - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       fifo_head;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  // Full is the registered flag, so a write while full drops even if a pop lands this cycle.
  assign push    = start & ~full;
  assign bit_end = (baud_cnt == BIT_LAST);
  assign pop     = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_end));

  sync_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .din    (data),
    .head   (fifo_head),
    .full   (full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // A pop always loads the next frame, overriding the STOP->IDLE exit for back-to-back bytes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      tx         <= IDLE_LEVEL;
      done       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: baud_cnt <= '0;
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= shift_reg[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity_bit;
`else
              state <= STOP;
              tx    <= IDLE_LEVEL;
`endif
            end else begin
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
              bit_idx   <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= IDLE_LEVEL;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
        end
      endcase
      if (pop) begin
        state     <= START;
        tx        <= ~IDLE_LEVEL;
        shift_reg <= fifo_head;
        baud_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
        parity_bit <= ^fifo_head;
`endif
      end
    end
  end

  // An accepted write raises busy on the next cycle, before the FIFO count is visible to the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      busy <= push | (state != IDLE) | (fifo_count != '0);
      if (start & full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered at a 4-clock bit period; honours UART_TX_PARITY_EN.
module tb_uart_tx_buffered;

  localparam int BD    = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * BD;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx, busy, done, full, overflow;
  logic [4:0] fifo_count;

  uart_tx_buffered #(
    .CLK_FREQ  (400),
    .BAUD      (100),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .data      (data),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .full      (full),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int         passed = 0;
  int         total = 0;
  int         cyc = 0;
  int         done_count = 0;
  int         done_times[$];
  logic [7:0] exp_q[$];
  int         d0, n0, t0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 30 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic check_spacing(input string name, input int first, input int cnt);
    for (int k = 1; k < cnt; k++) begin
      if (done_times.size() > first + k)
        check(name, done_times[first+k] - done_times[first+k-1], FRAME);
      else
        check(name, done_times.size(), first + cnt);
    end
  endtask

  // Done pulse recorder.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_count++;
        done_times.push_back(cyc);
      end
    end
  end

  // Serial-line receiver: decodes each frame mid-bit and checks it against the expected queue.
  initial begin : frame_monitor
    bit         mon_active = 1'b0;
    int         mon_cyc = 0;
    logic [0:11] mon_bits;
    logic [7:0] rx, e;
    mon_bits = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_active = 1'b0;
      end else begin
        if (mon_active) begin
          mon_cyc++;
          if (mon_cyc % BD == BD / 2 && mon_cyc < FRAME) mon_bits[mon_cyc/BD] = tx;
          if (mon_cyc == FRAME) begin
            for (int i = 0; i < 8; i++) rx[i] = mon_bits[i+1];
            check("start_bit", mon_bits[0], 0);
            check("stop_bit", mon_bits[NB-1], 1);
            check("done_at_frame_end", done, 1);
            check("frame_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("rx_byte", rx, e);
`ifdef UART_TX_PARITY_EN
              check("parity_bit", mon_bits[9], ^e);
`endif
            end
            mon_active = 1'b0;
          end
        end
        if (!mon_active && tx === 1'b0) begin
          mon_active = 1'b1;
          mon_cyc = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus;
    // Reset values
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_full", full, 0);
    check("reset_count", fifo_count, 0);
    check("reset_overflow", overflow, 0);

    // Single byte 0xA5 from idle
    start = 1'b1; data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk);
    start = 1'b0; data = 8'h3C;
    check("count_after_write", fifo_count, 1);
    check("busy_rise", busy, 1);
    check("tx_idle_before_start", tx, 1);
    @(negedge clk);
    check("tx_fall", tx, 0);
    check("count_after_pop", fifo_count, 0);
    t0 = cyc;
    for (int n = 0; n < FRAME + 10; n++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    check("done_latency", cyc - t0, FRAME);
    check("busy_at_done", busy, 1);
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("busy_fall", busy, 0);

    // Burst of three bytes on consecutive cycles
    d0 = done_count; n0 = done_times.size();
    start = 1'b1; data = 8'hFF; exp_q.push_back(8'hFF);
    @(negedge clk);
    data = 8'h00; exp_q.push_back(8'h00);
    @(negedge clk);
    data = 8'h55; exp_q.push_back(8'h55);
    @(negedge clk);
    start = 1'b0;
    check("burst_count_peak", fifo_count, 2);
    wait_drain("burst_drain");
    check("burst_frames", done_count - d0, 3);
    check_spacing("burst_spacing", n0, 3);

    // Push landing on the stop-end pop keeps the count steady
    d0 = done_count; n0 = done_times.size();
    start = 1'b1; data = 8'h81; exp_q.push_back(8'h81);
    @(negedge clk);
    data = 8'h42; exp_q.push_back(8'h42);
    @(negedge clk);
    start = 1'b0;
    repeat (FRAME - 1) @(negedge clk);
    start = 1'b1; data = 8'hE7; exp_q.push_back(8'hE7);
    @(negedge clk);
    start = 1'b0;
    check("simul_count", fifo_count, 1);
    check("simul_done", done, 1);
    check("simul_no_gap", tx, 0);
    wait_drain("simul_drain");
    check("simul_frames", done_count - d0, 3);
    check_spacing("simul_spacing", n0, 3);

    // Overflow: DEPTH+2 back-to-back writes, the last one dropped
    d0 = done_count;
    for (int i = 0; i < DEPTH + 2; i++) begin
      start = 1'b1;
      data = 8'(i * 7 + 1);
      if (i < DEPTH + 1) exp_q.push_back(8'(i * 7 + 1));
      @(negedge clk);
    end
    start = 1'b0;
    check("ovf_count", fifo_count, DEPTH);
    check("ovf_full", full, 1);
    check("ovf_flag", overflow, 1);
    wait_drain("ovf_drain");
    check("ovf_frames", done_count - d0, DEPTH + 1);
    check("ovf_sticky", overflow, 1);
    check("ovf_full_cleared", full, 0);

    // Reset during data bit 3 aborts the frame
    d0 = done_count;
    start = 1'b1; data = 8'hC3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    repeat (17) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_tx_immediate", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_overflow_cleared", overflow, 0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (FRAME) @(negedge clk);
    check("rst_no_done", done_count - d0, 0);
    check("rst_count", fifo_count, 0);
    check("rst_busy_after", busy, 0);
    check("rst_tx_idle", tx, 1);

    // Done-paced producer with parity-sensitive bytes
    d0 = done_count;
    start = 1'b1; data = 8'h07; exp_q.push_back(8'h07);
    @(negedge clk);
    start = 1'b0;
    wait_drain("byte07_drain");
    start = 1'b1; data = 8'h03; exp_q.push_back(8'h03);
    @(negedge clk);
    start = 1'b0;
    wait_drain("byte03_drain");
    check("paced_frames", done_count - d0, 2);
  endtask

  task automatic checkOutput;
    repeat (4) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Byte-serial UART transmitter with an internal FIFO.
- Sits directly downstream of the game/frame data sender FSM, which pushes header, object-state and image bytes.
- Absorbs bursts so the sender can queue bytes back-to-back, and serialises them 8N1 (optionally 8E1) on the board TX pin.
- Keeps the start/data/busy/done handshake the sender already uses.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate. Bit period BIT_DIV = CLK_FREQ/BAUD, rounded to nearest (868 at defaults).
- FIFO_DEPTH, 16: FIFO entries. Must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  write strobe; pushes data into the FIFO when not full.
- data  in  8  byte to queue.
- tx  out  1  serial line, idle high.
- busy  out  1  high while the FIFO is non-empty or a frame is on the line.
- done  out  1  one-cycle pulse when a frame's stop bit completes.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when start arrives while full. Cleared only by reset.

Behaviour:
- Reset (async, reset_n=0): tx=1, busy=0, done=0, full=0, fifo_count=0, overflow=0, FSM=IDLE, all counters 0, FIFO pointers 0. Reset mid-frame aborts the frame immediately; tx returns high in the same cycle.
- Write: start=1 with full=0 at edge N stores data; fifo_count increments at N+1.
- Write while full: the byte is dropped and overflow is set. This holds even if a pop happens in the same cycle, because full is the registered value.
- Simultaneous push and pop: accepted; fifo_count unchanged.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
- IDLE: if the FIFO is non-empty, pop the head into the shift register, go to START, and drive tx=0 from the next cycle.
- Timing from an empty, idle block: start at edge N → tx falls at N+2.
- Bit timing: each bit lasts exactly BIT_DIV cycles. The baud counter is reset on every state entry; no free-running tick.
- START (tx=0) → DATA.
- DATA: 8 bits, LSB first; a 3-bit index counts 0..7. After bit 7 → PARITY if compiled in, else STOP.
- STOP: tx=1 for BIT_DIV cycles. At the end of the period, done pulses for 1 cycle.
  - If the FIFO is non-empty in that same cycle, pop and go directly to START. There is no idle gap between frames: one frame = 10×BIT_DIV cycles (11× with parity).
  - If the FIFO is empty, go to IDLE.
- busy = (FSM≠IDLE) | (fifo_count≠0), registered. It is high from N+1 after an accepted write, and falls in the cycle after the final done.
- Sender compatibility: a producer that waits for done before the next start still works and sees one done per byte.
- data is sampled only at the write edge; later changes have no effect.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted after DATA and transmits even parity (XOR of the 8 data bits) for BIT_DIV cycles. Frame = 11 bit periods.
- Undefined: no PARITY state or logic; 8N1, 10 bit periods.
- Ports and handshake are identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - a function calc_bit_div(clk_freq, baud), which does rounded division;
  - constants IDLE_LEVEL=1 and DATA_BITS=8.
- Sub-module: sync_byte_fifo (parameter DEPTH), a single-clock FIFO with push/pop/full/empty/count and a show-ahead head output.
- The shifter FSM lives in uart_tx_buffered.

Test Plan (BIT_DIV forced to 4 where noted):
- Single byte: push 0xA5 from reset → tx is 0 at N+2, then bits 1,0,1,0,0,1,0,1 (LSB first), then 1. Each bit lasts 868 cycles. done pulses once, 8680 cycles after tx falls. busy is high from N+1 and clears one cycle after done.
- Burst (BIT_DIV=4): push 0xFF, 0x00, 0x55 on 3 consecutive cycles → fifo_count reaches 2 then drains. Frames are contiguous, with the start bit right after each stop bit. 3 done pulses spaced 40 cycles apart.
- Overflow (DEPTH=16, BIT_DIV=4): push 18 bytes on consecutive cycles → first byte popped; 16 stored; 18th byte dropped; full=1; overflow=1 and stays set. Exactly 17 frames are sent.
- Simultaneous push/pop: at a STOP end with fifo_count=1, push a new byte → fifo_count stays 1. Next frame starts with no gap.
- Mid-frame reset: assert reset_n=0 during DATA bit 3 → tx=1 immediately. After release: fifo_count=0, busy=0, no done pulse.
- With UART_TX_PARITY_EN: push 0x07 → parity bit is 1 and the frame is 11 bit periods. Push 0x03 → parity bit is 0.
